// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: game state machine, BCD score, ball reserve and pause timer.
// All outputs come straight from registers so the pixel path sees no glitches.
module pong_game_ctrl #(
    parameter int unsigned BALLS_INIT  = 3,
    parameter int unsigned TIMER_TICKS = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refr_tick,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [1:0] ball,
    output logic [3:0] text_sel,
    output logic       graph_still,
    output logic       timer_up
);

    localparam int unsigned TW = 7;
    localparam int unsigned BW = 2;

    localparam logic [3:0] TXT_NEWGAME = 4'b0111;
    localparam logic [3:0] TXT_PLAY    = 4'b0001;
    localparam logic [3:0] TXT_OVER    = 4'b1001;

    typedef enum logic [1:0] {
        S_NEWGAME = 2'd0,
        S_PLAY    = 2'd1,
        S_NEWBALL = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    state_t          state_q;
    logic [3:0]      dig0_q, dig1_q;
    logic [3:0]      dig0_d, dig1_d;
    logic [BW-1:0]   ball_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      text_sel_q;
    logic            graph_still_q;
    logic            timer_up_q;
    logic            timer_load_c;

    // BCD increment of the score, wrapping 99 -> 00
    always_comb begin
        dig0_d = dig0_q + 4'd1;
        dig1_d = dig1_q;
        if (dig0_q >= 4'd9) begin
            dig0_d = 4'd0;
            dig1_d = (dig1_q >= 4'd9) ? 4'd0 : dig1_q + 4'd1;
        end
    end

    // Pause timer: a load on a miss wins over the per-frame decrement
    always_comb begin
        timer_load_c = (state_q == S_PLAY) && miss;
        timer_d      = timer_q;
        if (timer_load_c) begin
            timer_d = TW'(TIMER_TICKS);
        end else if (refr_tick && (timer_q != '0)) begin
            timer_d = timer_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_NEWGAME;
            dig0_q        <= 4'd0;
            dig1_q        <= 4'd0;
            ball_q        <= BW'(BALLS_INIT);
            timer_q       <= '0;
            timer_up_q    <= 1'b1;
            text_sel_q    <= TXT_NEWGAME;
            graph_still_q <= 1'b1;
        end else begin
            timer_q    <= timer_d;
            timer_up_q <= (timer_d == '0);
            case (state_q)
                S_NEWGAME: begin
                    if (btn != 2'b00) begin
                        state_q       <= S_PLAY;
                        dig0_q        <= 4'd0;
                        dig1_q        <= 4'd0;
                        ball_q        <= BW'(BALLS_INIT - 1);
                        text_sel_q    <= TXT_PLAY;
                        graph_still_q <= 1'b0;
                    end
                end
                S_PLAY: begin
                    // miss beats a coincident hit, leaving the score untouched
                    if (miss) begin
                        graph_still_q <= 1'b1;
                        if (ball_q == '0) begin
                            state_q    <= S_OVER;
                            text_sel_q <= TXT_OVER;
                        end else begin
                            state_q    <= S_NEWBALL;
                            ball_q     <= ball_q - BW'(1);
                            text_sel_q <= TXT_PLAY;
                        end
                    end else if (hit) begin
                        dig0_q <= dig0_d;
                        dig1_q <= dig1_d;
                    end
                end
                S_NEWBALL: begin
                    if ((timer_q == '0) && (btn != 2'b00)) begin
                        state_q       <= S_PLAY;
                        text_sel_q    <= TXT_PLAY;
                        graph_still_q <= 1'b0;
                    end
                end
                S_OVER: begin
                    if (timer_q == '0) begin
                        state_q       <= S_NEWGAME;
                        ball_q        <= BW'(BALLS_INIT);
                        text_sel_q    <= TXT_NEWGAME;
                        graph_still_q <= 1'b1;
                    end
                end
                default: state_q <= S_NEWGAME;
            endcase
        end
    end

    assign dig0        = dig0_q;
    assign dig1        = dig1_q;
    assign ball        = ball_q;
    assign text_sel    = text_sel_q;
    assign graph_still = graph_still_q;
    assign timer_up    = timer_up_q;

endmodule
